// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus arbiter.
//   state_t        : arbiter FSM encoding (IDLE/ADDR/DATA)
//   HTRANS_*       : AHB transfer types driven by the arbiter
//   REQ_CORE/DBG   : requester indices into the packed request vectors
//   owner_onehot() : index -> one-hot requester vector
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam int REQ_CORE = 0;
    localparam int REQ_DBG  = 1;
    localparam int NUM_REQ  = REQ_DBG + 1;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic idx);
        owner_onehot      = '0;
        owner_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector (bit REQ_CORE, bit REQ_DBG)
//   take     : the caller consumes the winner this cycle (advances pointer)
//   gnt      : one-hot winner, zero when nobody requests
//   sel      : winner index
// The pointer names the requester that wins a tie; after a grant it moves
// to the other requester, so a requester held high alternates with its peer.
module rr_arb2
    import dbus_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic [NUM_REQ-1:0] gnt,
    output logic               sel
);

    logic prio_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio_q <= 1'(REQ_CORE);
        else if (take && |req)
            prio_q <= ~sel;
    end

    always_comb begin
        sel = prio_q;
        if (!req[prio_q])
            sel = ~prio_q;
        gnt = '0;
        if (|req)
            gnt[sel] = 1'b1;
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Arbitrates a core and a debug requester onto a single AHB-lite master port.
//   clk_in, rst_in         : clock, asynchronous active-high reset
//   req_in/wr_in           : per-requester request and write flag
//   addr_in/wdata_in/mask_in : packed per-requester address, data, byte mask
//   gnt_out/done_out       : one-hot grant pulse and completion pulse
//   rdata_out/err_out      : read data (held) and error, valid with done_out
//   haddr/htrans/hwrite/hwmask/hwdata_out : AHB master outputs
//   hrdata_in/hready_in/hresp_in          : AHB slave response
// Zero-wait timing: gnt at n, address phase at n+1, done at n+2. A request
// pending at completion is granted in the completion cycle, so back-to-back
// transfers issue every two cycles.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [NUM_REQ-1:0]         wr_in,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr_in,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata_in,
    input  logic [NUM_REQ*DATA_W/8-1:0] mask_in,
    output logic [NUM_REQ-1:0]         gnt_out,
    output logic [NUM_REQ-1:0]         done_out,
    output logic [DATA_W-1:0]          rdata_out,
    output logic                       err_out,
    output logic [ADDR_W-1:0]          haddr_out,
    output logic [1:0]                 htrans_out,
    output logic                       hwrite_out,
    output logic [DATA_W/8-1:0]        hwmask_out,
    output logic [DATA_W-1:0]          hwdata_out,
    input  logic [DATA_W-1:0]          hrdata_in,
    input  logic                       hready_in,
    input  logic                       hresp_in
);

    localparam int MASK_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Per-requester views of the packed buses.
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_v;
    logic [NUM_REQ-1:0][MASK_W-1:0] mask_v;

    assign addr_v  = addr_in;
    assign wdata_v = wdata_in;
    assign mask_v  = mask_in;

    state_t              state_q, state_d;
    logic                owner_q;
    logic                hold_wr_q;
    logic [MASK_W-1:0]   hold_mask_q;
    logic [DATA_W-1:0]   hold_wdata_q;
    logic [ADDR_W-1:0]   haddr_q;
    logic [DATA_W-1:0]   hwdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                arb_take;
    logic                arb_sel;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic                done_fire;
    logic                grant_fire;

    // Grants happen only in IDLE or in the completion cycle, so a request
    // from the current owner is naturally ignored until completion. Gating
    // with rst_in keeps gnt_out low while reset is asserted.
    assign done_fire  = (state_q == DATA) && hready_in;
    assign arb_take   = !rst_in && ((state_q == IDLE) || done_fire);
    assign grant_fire = arb_take && (|req_in);

    rr_arb2 u_arb (
        .clk  (clk_in),
        .rst  (rst_in),
        .req  (req_in),
        .take (arb_take),
        .gnt  (arb_gnt),
        .sel  (arb_sel)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        gnt_out    = '0;
        done_out   = '0;
        err_out    = 1'b0;
        htrans_out = HTRANS_IDLE;
        hwrite_out = 1'b0;
        hwmask_out = '0;
        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    gnt_out = arb_gnt;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                htrans_out = HTRANS_NONSEQ;
                hwrite_out = hold_wr_q;
                hwmask_out = hold_wr_q ? hold_mask_q : '0;
                if (hready_in)
                    state_d = DATA;
            end
            DATA: begin
                if (hready_in) begin
                    done_out = owner_onehot(owner_q);
                    err_out  = hresp_in;
                    if (grant_fire) begin
                        gnt_out = arb_gnt;
                        state_d = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            owner_q      <= 1'(REQ_CORE);
            hold_wr_q    <= 1'b0;
            hold_mask_q  <= '0;
            hold_wdata_q <= '0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
            rdata_q      <= '0;
        end else begin
            if (grant_fire) begin
                owner_q      <= arb_sel;
                hold_wr_q    <= wr_in[arb_sel];
                hold_mask_q  <= mask_v[arb_sel];
                hold_wdata_q <= wdata_v[arb_sel];
                haddr_q      <= addr_v[arb_sel] & WORD_MASK;
            end
            // Write data moves to the bus as the address phase is accepted
            // and then stays put through any data-phase wait states.
            if (state_q == ADDR && hready_in)
                hwdata_q <= hold_wdata_q;
            // hold_wr_q still describes the completing transfer here even if
            // a new grant loads it on this same edge.
            if (done_fire && !hold_wr_q)
                rdata_q <= hrdata_in;
        end
    end

    assign haddr_out  = haddr_q;
    assign hwdata_out = hwdata_q;
    // Read data is presented in the completion cycle itself and held after.
    assign rdata_out  = (done_fire && !hold_wr_q) ? hrdata_in : rdata_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter. Stimulus pushes expected completions into
// a scoreboard queue; a forked monitor pops and checks on every done_out.
module tb_dbus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [1:0]  req_in, wr_in;
    logic [63:0] addr_in, wdata_in;
    logic [7:0]  mask_in;
    logic [1:0]  gnt_out, done_out;
    logic [31:0] rdata_out;
    logic        err_out;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [3:0]  hwmask_out;
    logic [31:0] hwdata_out;
    logic [31:0] hrdata_in;
    logic        hready_in, hresp_in;

    typedef struct {
        logic [1:0]  done;
        logic        err;
        logic        rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .wr_in(wr_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .mask_in(mask_in),
        .gnt_out(gnt_out), .done_out(done_out), .rdata_out(rdata_out),
        .err_out(err_out), .haddr_out(haddr_out), .htrans_out(htrans_out),
        .hwrite_out(hwrite_out), .hwmask_out(hwmask_out), .hwdata_out(hwdata_out),
        .hrdata_in(hrdata_in), .hready_in(hready_in), .hresp_in(hresp_in)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [1:0] d, input logic e, input logic rd, input logic [31:0] rv);
        exp_t x;
        x.done = d; x.err = e; x.rd = rd; x.rdata = rv;
        sb.push_back(x);
    endtask

    task automatic chk_aphase(input string name, input logic [31:0] a, input logic w, input logic [3:0] m);
        chk(name, {haddr_out, htrans_out, hwrite_out, hwmask_out}, {a, 2'b10, w, m});
    endtask

    logic [1:0] gexp [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    initial begin
        rst_in = 1'b1; req_in = '0; wr_in = '0; addr_in = '0; wdata_in = '0;
        mask_in = '0; hrdata_in = '0; hready_in = 1'b1; hresp_in = 1'b0;

        // Completion monitor, decoupled from the stimulus sequence.
        fork
            forever begin
                @(negedge clk_in);
                if (!rst_in && done_out != 2'b00) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done got=%0b exp=none at %0t", done_out, $time);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("done_owner", 64'(done_out), 64'(e.done));
                        chk("done_err", 64'(err_out), 64'(e.err));
                        if (e.rd) chk("done_rdata", 64'(rdata_out), 64'(e.rdata));
                    end
                end
            end
        join_none

        // Reset state
        @(negedge clk_in);
        chk("reset_ctl", {gnt_out, done_out, err_out, htrans_out, hwrite_out, hwmask_out}, 64'd0);
        chk("reset_data", {haddr_out, hwdata_out}, 64'd0);
        chk("reset_rdata", 64'(rdata_out), 64'd0);
        cyc();
        rst_in = 1'b0;

        // Core write, zero wait
        req_in = 2'b01; wr_in = 2'b01; addr_in = {32'h0, 32'h0000_1006};
        wdata_in = {32'h0, 32'h00AB_0000}; mask_in = 8'h04;
        push(2'b01, 1'b0, 1'b0, 32'h0);
        @(negedge clk_in); chk("t1_gnt", 64'(gnt_out), 64'(2'b01));
        cyc(); req_in = 2'b00;
        @(negedge clk_in); chk_aphase("t1_aphase", 32'h0000_1004, 1'b1, 4'b0100);
        cyc();
        @(negedge clk_in); chk("t1_hwdata", 64'(hwdata_out), 64'h00AB_0000);
        chk("t1_htrans_data", 64'(htrans_out), 64'(2'b00));
        cyc();

        // Debug read, two data-phase wait states, mask forced to zero
        req_in = 2'b10; wr_in = 2'b00; addr_in = {32'h0000_2000, 32'h0};
        wdata_in = {32'h1234_5678, 32'h0}; mask_in = 8'hF0;
        push(2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk_in); chk("t2_gnt", 64'(gnt_out), 64'(2'b10));
        cyc(); req_in = 2'b00;
        @(negedge clk_in); chk_aphase("t2_aphase", 32'h0000_2000, 1'b0, 4'b0000);
        cyc(); hready_in = 1'b0; hrdata_in = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            chk("t2_wait_done", 64'(done_out), 64'd0);
            chk("t2_wait_hwdata", 64'(hwdata_out), 64'h1234_5678);
            cyc();
        end
        hready_in = 1'b1;
        @(negedge clk_in); chk("t2_done_hwdata", 64'(hwdata_out), 64'h1234_5678);
        cyc(); hrdata_in = 32'h0;
        @(negedge clk_in); chk("t2_rdata_held", 64'(rdata_out), 64'hDEAD_BEEF);
        cyc();

        // Both requesting from reset: core, debug, core back-to-back
        rst_in = 1'b1; cyc(); rst_in = 1'b0;
        req_in = 2'b11; wr_in = 2'b11; addr_in = {32'h0000_0200, 32'h0000_0100};
        wdata_in = {32'h2, 32'h1}; mask_in = 8'hFF;
        push(2'b01, 1'b0, 1'b0, 32'h0);
        push(2'b10, 1'b0, 1'b0, 32'h0);
        push(2'b01, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk($sformatf("t3_gnt_c%0d", i), 64'(gnt_out), 64'(gexp[i]));
            if (i == 1) chk("t3_haddr_core", 64'(haddr_out), 64'h100);
            if (i == 3) chk("t3_haddr_dbg", 64'(haddr_out), 64'h200);
            cyc();
        end
        req_in = 2'b00;
        cyc(); cyc();

        // Error response, then a clean read
        req_in = 2'b01; wr_in = 2'b01; addr_in = {32'h0, 32'h0000_3000};
        push(2'b01, 1'b1, 1'b0, 32'h0);
        @(negedge clk_in); chk("t4_gnt", 64'(gnt_out), 64'(2'b01));
        cyc(); req_in = 2'b00;
        cyc(); hresp_in = 1'b1;
        cyc(); hresp_in = 1'b0;
        req_in = 2'b01; wr_in = 2'b00; addr_in = {32'h0, 32'h0000_3004};
        push(2'b01, 1'b0, 1'b1, 32'hCAFE_F00D);
        @(negedge clk_in); chk("t4_gnt2", 64'(gnt_out), 64'(2'b01));
        cyc(); req_in = 2'b00;
        cyc(); hrdata_in = 32'hCAFE_F00D;
        cyc();

        // Address phase stalled 3 cycles; debug request waits meanwhile
        req_in = 2'b01; wr_in = 2'b01; addr_in = {32'h0, 32'h0000_0404};
        wdata_in = {32'h0, 32'h5555_AAAA}; mask_in = 8'h03;
        push(2'b01, 1'b0, 1'b0, 32'h0);
        @(negedge clk_in); chk("t5_gnt", 64'(gnt_out), 64'(2'b01));
        cyc();
        req_in = 2'b10; wr_in = 2'b00; addr_in = {32'h0000_0500, 32'h0000_0404};
        hready_in = 1'b0;
        push(2'b10, 1'b0, 1'b1, 32'h0BAD_CAFE);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk_aphase("t5_stall_aphase", 32'h0000_0404, 1'b1, 4'b0011);
            chk("t5_stall_gnt", 64'(gnt_out), 64'd0);
            cyc();
        end
        hready_in = 1'b1;
        @(negedge clk_in); chk("t5_accept_gnt", 64'(gnt_out), 64'd0);
        cyc();
        @(negedge clk_in); chk("t5_next_gnt", 64'(gnt_out), 64'(2'b10));
        cyc(); req_in = 2'b00;
        @(negedge clk_in); chk_aphase("t5_dbg_aphase", 32'h0000_0500, 1'b0, 4'b0000);
        cyc(); hrdata_in = 32'h0BAD_CAFE;
        cyc();

        // Reset in the middle of a stalled data phase
        req_in = 2'b01; wr_in = 2'b01; addr_in = {32'h0, 32'h0000_0600};
        @(negedge clk_in); chk("t6_gnt", 64'(gnt_out), 64'(2'b01));
        cyc(); req_in = 2'b00;
        @(negedge clk_in); chk("t6_htrans", 64'(htrans_out), 64'(2'b10));
        cyc(); hready_in = 1'b0;
        #2 rst_in = 1'b1; req_in = 2'b11;
        @(negedge clk_in);
        chk("t6_rst_ctl", {gnt_out, done_out, err_out, htrans_out, hwrite_out, hwmask_out}, 64'd0);
        chk("t6_rst_data", {haddr_out, hwdata_out}, 64'd0);
        cyc();
        rst_in = 1'b0; hready_in = 1'b1;
        push(2'b01, 1'b0, 1'b0, 32'h0);
        @(negedge clk_in); chk("t6_post_gnt", 64'(gnt_out), 64'(2'b01));
        cyc(); req_in = 2'b00;
        repeat (4) cyc();

        @(negedge clk_in);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of requesters and bus.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset; asynchronous, active-high.
REQ-005 req_in  input  2  transfer request per requester; bit0 core (from store/load units), bit1 debug.
REQ-006 wr_in  input  2  1 = write, 0 = read, per requester.
REQ-007 addr_in  input  64  packed byte addresses; [31:0] core, [63:32] debug.
REQ-008 wdata_in  input  64  packed lane-aligned write data, same packing.
REQ-009 mask_in  input  8  packed byte-enable masks; [3:0] core, [7:4] debug.
REQ-010 gnt_out  output  2  one-hot, one-cycle grant pulse.
REQ-011 done_out  output  2  one-hot, one-cycle completion pulse to the owner.
REQ-012 rdata_out  output  32  read data, valid with done_out, held until next completion.
REQ-013 err_out  output  1  error flag, valid with done_out.
REQ-014 haddr_out  output  32  AHB address, word-aligned {addr[31:2],2'b00}.
REQ-015 htrans_out  output  2  AHB transfer type; only IDLE 2'b00 and NONSEQ 2'b10.
REQ-016 hwrite_out  output  1  AHB write strobe.
REQ-017 hwmask_out  output  4  byte-lane write mask; 4'b0000 for reads.
REQ-018 hwdata_out  output  32  AHB write data, driven in data phase.
REQ-019 hrdata_in  input  32  AHB read data.
REQ-020 hready_in  input  1  AHB ready; 0 = wait state.
REQ-021 hresp_in  input  1  AHB error response.

Function
REQ-022 FSM states SHALL be IDLE, ADDR, DATA.
REQ-023 IDLE: if any req_in bit is set, SHALL pulse gnt_out for the arbitration winner, capture its wr/addr/wdata/mask into holding registers, and go to ADDR next cycle.
REQ-024 Arbitration SHALL be two-way round-robin: on simultaneous requests the requester not granted last wins; after reset the core has priority.
REQ-025 ADDR: SHALL drive htrans_out=2'b10, haddr_out, hwrite_out and hwmask_out from the holding registers; on hready_in=1 go to DATA, else hold all outputs stable.
REQ-026 DATA: SHALL drive hwdata_out from the holding register, stable across wait states; htrans_out=2'b00.
REQ-027 DATA with hready_in=1: SHALL pulse done_out for the owner, set err_out=hresp_in, and, for reads, register hrdata_in into rdata_out.
REQ-028 DATA completion with a request pending: SHALL grant and capture it in that same cycle and go directly to ADDR; else go to IDLE.
REQ-029 Zero-wait latency SHALL be: gnt at cycle n, address phase at n+1, done at n+2.
REQ-030 A requester SHALL hold req_in until gnt_out; req_in while that requester owns the bus SHALL be ignored until the completion cycle.
REQ-031 In IDLE, htrans_out=2'b00, hwrite_out=0, hwmask_out=0; haddr_out holds its last value.
REQ-032 A read SHALL force hwmask_out=0 regardless of mask_in.

Reset
REQ-033 rst_in SHALL immediately force state IDLE, round-robin pointer to core, and gnt_out, done_out, err_out, htrans_out, hwrite_out, hwmask_out, haddr_out, hwdata_out and rdata_out to 0.
REQ-034 A transfer in flight at reset SHALL be abandoned with no done_out.

Structure
REQ-035 Shared package dbus_pkg SHALL hold the state encoding (IDLE 2'b00, ADDR 2'b01, DATA 2'b10), HTRANS_IDLE/HTRANS_NONSEQ, and requester indices REQ_CORE=0 and REQ_DBG=1.
REQ-036 Round-robin selection SHALL be the sub-module rr_arb2, comprising the pointer flop and the combinational winner.

Verification
REQ-037 Core write, addr 0x0000_1006, wdata 0x00AB_0000, mask 4'b0100, hready=1 -> gnt=01 at c0; c1 haddr=0x0000_1004, htrans=10, hwrite=1, hwmask=0100; c2 hwdata=0x00AB_0000, done=01, err=0.
REQ-038 Debug read, addr 0x0000_2000, hready low 2 cycles in DATA, hrdata=0xDEAD_BEEF -> done=10 at c4, rdata_out=0xDEAD_BEEF, hwdata stable throughout.
REQ-039 Both requesting from reset, held high -> grant order core, debug, core; back-to-back: gnt at c0, c2, c4.
REQ-040 Core write with hresp=1, hready=1 in DATA -> done=01, err=1; next transfer err=0.
REQ-041 rst_in asserted mid-DATA with hready=0 -> same-cycle htrans=00, no done; first post-reset simultaneous request grants core.
REQ-042 Address phase stalled 3 cycles (hready=0) -> haddr, htrans, hwrite and hwmask unchanged; no second gnt issued.
